tri_frame_scheduler: RTL and testbench

- Per-frame sequencer that feeds the graphics pipeline.
- On a frame start it walks triangle IDs 0..num_tri_in-1 and reads each triangle's vertices from the triangle BRAM. It then presents one triangle at a time to the pipeline's tri_id/P valid-ready input.
- It counts completed triangles from the rasterizer's last-pixel beats. Once all are drained it pulses frame_done and flips the framebuffer select.
- Sits between the top-level frame controller / triangle BRAM and the pipeline's triangle input.

---
 rtl/tri_frame_scheduler_if.sv | 25 ++
 rtl/tri_frame_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_tri_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_frame_scheduler_if.sv
// Triangle-side bus of the frame scheduler: BRAM read port toward the
// triangle store and the tri_id/P valid-ready channel into the pipeline.
// master = scheduler, slave = BRAM + pipeline side.
interface tri_frame_scheduler_if #(
   parameter int P_WIDTH = 16,
   parameter int TW      = 11
);
   logic [TW-1:0]                  tri_addr_out;
   logic                           tri_rd_en_out;
   logic [9*P_WIDTH-1:0]           tri_data_in;
   logic                           valid_out;
   logic                           ready_in;
   logic [TW-1:0]                  tri_id_out;
   logic [2:0][2:0][P_WIDTH-1:0]   P_out;

   modport master (
      output tri_addr_out, tri_rd_en_out, valid_out, tri_id_out, P_out,
      input  tri_data_in, ready_in
   );

   modport slave (
      input  tri_addr_out, tri_rd_en_out, valid_out, tri_id_out, P_out,
      output tri_data_in, ready_in
   );
endinterface

// File: rtl/tri_frame_scheduler.sv
// Per-frame triangle sequencer: fetches each triangle from the triangle BRAM,
// hands it to the pipeline over a valid/ready channel, counts rasterizer
// completions, then pulses frame_done and flips the framebuffer select.
// Optional macro SCHED_WATCHDOG_EN adds a DRAIN timeout (parameter
// WATCHDOG_CYCLES and sticky output timeout_out).
module tri_frame_scheduler #(
   parameter int P_WIDTH      = 16,
   parameter int NUM_TRI      = 2048,
   parameter int BRAM_LATENCY = 2,
`ifdef SCHED_WATCHDOG_EN
   parameter int WATCHDOG_CYCLES = 1048576,
`endif
   localparam int TW = $clog2(NUM_TRI)
)(
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   input  logic [TW:0]                  num_tri_in,
   tri_frame_scheduler_if.master        bus,
   input  logic                         pix_valid_in,
   input  logic                         pix_ready_in,
   input  logic                         last_pixel_in,
   output logic                         busy_out,
   output logic                         frame_done_out,
   output logic                         fb_sel_out,
`ifdef SCHED_WATCHDOG_EN
   output logic                         timeout_out,
`endif
   output logic [TW:0]                  outstanding_out
);

   localparam int LW = $clog2(BRAM_LATENCY + 1);
`ifdef SCHED_WATCHDOG_EN
   localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_DRAIN, S_DONE
   } state_t;

   state_t                        r_state;
   logic [TW:0]                   r_n;
   logic [TW-1:0]                 r_id;
   logic [LW-1:0]                 r_lat;
   logic [TW-1:0]                 r_addr;
   logic                          r_rd_en;
   logic                          r_valid;
   logic [TW-1:0]                 r_tri_id;
   logic [2:0][2:0][P_WIDTH-1:0]  r_P;
   logic                          r_busy;
   logic                          r_frame_done;
   logic                          r_fb_sel;
   logic [TW:0]                   r_outstanding;
`ifdef SCHED_WATCHDOG_EN
   logic [WDW-1:0]                r_wd;
   logic                          r_timeout;
`endif

   logic                          w_start;
   logic                          w_issue;
   logic                          w_complete;
   logic [TW:0]                   w_n_clamped;
   logic [TW:0]                   w_outstanding_next;

   assign w_start     = (r_state == S_IDLE) && start_in;
   assign w_issue     = (r_state == S_PRESENT) && r_valid && bus.ready_in;
   assign w_complete  = pix_valid_in && pix_ready_in && last_pixel_in;
   assign w_n_clamped = (num_tri_in > (TW+1)'(NUM_TRI)) ? (TW+1)'(NUM_TRI) : num_tri_in;

   // Next outstanding count: coincident issue+completion cancel, and a
   // completion with nothing in flight is treated as spurious.
   always_comb begin
      w_outstanding_next = r_outstanding;
      if (w_issue && !w_complete)
         w_outstanding_next = r_outstanding + (TW+1)'(1);
      else if (w_complete && !w_issue && (r_outstanding != '0))
         w_outstanding_next = r_outstanding - (TW+1)'(1);
   end

   // In-flight triangle counter; each new frame starts from zero.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         r_outstanding <= '0;
      else if (w_start)
         r_outstanding <= '0;
      else
         r_outstanding <= w_outstanding_next;
   end

   // Frame sequencer with registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state      <= S_IDLE;
         r_n          <= '0;
         r_id         <= '0;
         r_lat        <= '0;
         r_addr       <= '0;
         r_rd_en      <= 1'b0;
         r_valid      <= 1'b0;
         r_tri_id     <= '0;
         r_P          <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_fb_sel     <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
         r_wd         <= '0;
         r_timeout    <= 1'b0;
`endif
      end else begin
         r_rd_en      <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_n    <= w_n_clamped;
                  r_id   <= '0;
                  r_busy <= 1'b1;
`ifdef SCHED_WATCHDOG_EN
                  r_wd      <= '0;
                  r_timeout <= 1'b0;
`endif
                  // An empty frame falls through DRAIN, whose exit
                  // condition (nothing outstanding) already holds.
                  r_state <= (w_n_clamped == '0) ? S_DRAIN : S_FETCH;
               end
            end
            S_FETCH: begin
               r_rd_en <= 1'b1;
               r_addr  <= r_id;
               r_lat   <= LW'(BRAM_LATENCY);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Read data lines up with the cycle the countdown hits zero.
               if (r_lat == '0) begin
                  r_P      <= bus.tri_data_in;
                  r_tri_id <= r_id;
                  r_valid  <= 1'b1;
                  r_state  <= S_PRESENT;
               end else begin
                  r_lat <= r_lat - LW'(1);
               end
            end
            S_PRESENT: begin
               if (bus.ready_in) begin
                  r_valid <= 1'b0;
                  if ({1'b0, r_id} == r_n - (TW+1)'(1)) begin
                     r_state <= S_DRAIN;
`ifdef SCHED_WATCHDOG_EN
                     r_wd    <= '0;
`endif
                  end else begin
                     r_id    <= r_id + TW'(1);
                     r_state <= S_FETCH;
                  end
               end
            end
            S_DRAIN: begin
               if (w_outstanding_next == '0) begin
                  r_state <= S_DONE;
`ifdef SCHED_WATCHDOG_EN
               end else if (w_complete) begin
                  r_wd <= '0;
               end else if (r_wd == WDW'(WATCHDOG_CYCLES - 1)) begin
                  r_state   <= S_DONE;
                  r_timeout <= 1'b1;
               end else begin
                  r_wd <= r_wd + WDW'(1);
`endif
               end
            end
            S_DONE: begin
               r_frame_done <= 1'b1;
               r_fb_sel     <= ~r_fb_sel;
               r_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.tri_addr_out  = r_addr;
   assign bus.tri_rd_en_out = r_rd_en;
   assign bus.valid_out     = r_valid;
   assign bus.tri_id_out    = r_tri_id;
   assign bus.P_out         = r_P;
   assign busy_out          = r_busy;
   assign frame_done_out    = r_frame_done;
   assign fb_sel_out        = r_fb_sel;
   assign outstanding_out   = r_outstanding;
`ifdef SCHED_WATCHDOG_EN
   assign timeout_out       = r_timeout;
`endif

endmodule

// File: tb/tb_tri_frame_scheduler.sv
// Directed bench for tri_frame_scheduler (P_WIDTH=16, NUM_TRI=2048,
// BRAM_LATENCY=2). A two-stage BRAM model and a completion generator that
// returns one last-pixel beat 5 cycles after each handshake surround the DUT.
module tb_tri_frame_scheduler;
   localparam int PW  = 16;
   localparam int NT  = 2048;
   localparam int TW  = 11;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst_in;
   logic          start_in;
   logic [TW:0]   num_tri_in;
   logic          pix_valid_in;
   logic          pix_ready_in;
   logic          last_pixel_in;
   logic          busy_out;
   logic          frame_done_out;
   logic          fb_sel_out;
   logic [TW:0]   outstanding_out;
`ifdef SCHED_WATCHDOG_EN
   logic          timeout_out;
`endif

   tri_frame_scheduler_if #(.P_WIDTH(PW), .TW(TW)) bus ();

   tri_frame_scheduler #(
      .P_WIDTH(PW), .NUM_TRI(NT), .BRAM_LATENCY(LAT)
`ifdef SCHED_WATCHDOG_EN
      , .WATCHDOG_CYCLES(100)
`endif
   ) dut (
      .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .num_tri_in(num_tri_in),
      .bus(bus),
      .pix_valid_in(pix_valid_in), .pix_ready_in(pix_ready_in), .last_pixel_in(last_pixel_in),
      .busy_out(busy_out), .frame_done_out(frame_done_out), .fb_sel_out(fb_sel_out),
`ifdef SCHED_WATCHDOG_EN
      .timeout_out(timeout_out),
`endif
      .outstanding_out(outstanding_out)
   );

   always #5 clk = ~clk;

   // Triangle store contents: vertex word i of triangle a is (9a+i) ^ 0x5A00.
   function automatic logic [9*PW-1:0] tri_word(input int a);
      logic [9*PW-1:0] w;
      for (int i = 0; i < 9; i++) w[i*PW +: PW] = PW'(a * 9 + i) ^ 16'h5A00;
      return w;
   endfunction

   // BRAM model: data appears LAT cycles after rd_en, garbage otherwise.
   logic [9*PW-1:0] bram_s1, bram_s2;
   always @(posedge clk) begin
      bram_s1 <= bus.tri_rd_en_out ? tri_word(int'(bus.tri_addr_out)) : {9{16'hDEAD}};
      bram_s2 <= bram_s1;
   end
   assign bus.tri_data_in = bram_s2;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Completion generator and monitor.
   int  rd_log[$];
   int  id_log[$];
   int  p_bad = 0;
   int  cyc = 0, hs_cyc = 0, done_cyc = 0;
   int  comp_sent = 0, comp_limit = 1 << 30;
   logic [5:0] pipe = '0;
   logic hs, fire, coin_pending = 1'b0;
   logic [TW:0] coin_prev;

   initial begin
      forever begin
         @(negedge clk); #1;
         cyc++;
         if (coin_pending && !rst_in)
            check_eq("coincident_outstanding", outstanding_out, coin_prev);
         coin_pending = 1'b0;
         hs = bus.valid_out && bus.ready_in;
         if (rst_in) begin
            pipe = '0;
            fire = 1'b0;
         end else begin
            pipe = {pipe[4:0], hs};
            fire = pipe[5] && (comp_sent < comp_limit);
         end
         if (fire) comp_sent++;
         last_pixel_in = fire;
         pix_valid_in  = fire;
         if (bus.tri_rd_en_out) rd_log.push_back(int'(bus.tri_addr_out));
         if (hs) begin
            id_log.push_back(int'(bus.tri_id_out));
            if (bus.P_out != tri_word(int'(bus.tri_id_out))) p_bad++;
            hs_cyc = cyc;
         end
         if (frame_done_out) done_cyc = cyc;
         if (hs && fire && !rst_in) begin
            coin_pending = 1'b1;
            coin_prev    = outstanding_out;
         end
      end
   end

   task automatic clear_logs();
      rd_log.delete();
      id_log.delete();
      p_bad = 0;
   endtask

   // Present start_in for one sample edge; returns just after that edge.
   task automatic start_pulse(input int n);
      num_tri_in = (TW+1)'(n);
      start_in   = 1'b1;
      @(negedge clk);
      start_in   = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget, output int lat);
      lat = 0;
      while (!bus.valid_out && lat < budget) begin @(negedge clk); lat++; end
      check_eq({tag, "_valid_seen"}, bus.valid_out, 1'b1);
   endtask

   task automatic wait_done(input string tag, input int budget, output int lat);
      lat = 0;
      while (!frame_done_out && lat < budget) begin @(negedge clk); lat++; end
      check_eq({tag, "_done_seen"}, frame_done_out, 1'b1);
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, frame_done_out, 1'b0);
      check_eq({tag, "_busy_low"}, busy_out, 1'b0);
   endtask

   int lat, ones;

   initial begin
      rst_in = 1'b1; start_in = 1'b0; num_tri_in = '0;
      bus.ready_in = 1'b1; pix_ready_in = 1'b1;
      pix_valid_in = 1'b0; last_pixel_in = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("rst_valid", bus.valid_out, 1'b0);
      check_eq("rst_rd_en", bus.tri_rd_en_out, 1'b0);
      check_eq("rst_busy", busy_out, 1'b0);
      check_eq("rst_done", frame_done_out, 1'b0);
      check_eq("rst_fb_sel", fb_sel_out, 1'b0);
      check_eq("rst_outstanding", outstanding_out, 0);
      rst_in = 1'b0;
      @(negedge clk);

      // Basic 3-triangle frame.
      clear_logs();
      start_pulse(3);
      check_eq("basic_busy", busy_out, 1'b1);
      wait_valid("basic", 50, lat);
      check_eq("basic_first_valid_lat", lat, LAT + 2);
      wait_done("basic", 200, lat);
      check_eq("basic_fb_sel", fb_sel_out, 1'b1);
      check_eq("basic_outstanding", outstanding_out, 0);
      check_eq("basic_rd_count", rd_log.size(), 3);
      check_eq("basic_id_count", id_log.size(), 3);
      for (int i = 0; i < 3 && i < rd_log.size(); i++) check_eq("basic_rd_addr", rd_log[i], i);
      for (int i = 0; i < 3 && i < id_log.size(); i++) check_eq("basic_tri_id", id_log[i], i);
      check_eq("basic_P_bad", p_bad, 0);

      // Backpressure on triangle 1.
      clear_logs();
      start_pulse(3);
      lat = 0;
      while (!(bus.valid_out && bus.tri_id_out == TW'(1)) && lat < 100) begin
         @(negedge clk); lat++;
      end
      check_eq("bp_reach_tri1", bus.valid_out && bus.tri_id_out == TW'(1), 1'b1);
      bus.ready_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("bp_valid", bus.valid_out, 1'b1);
         check_eq("bp_tri_id", bus.tri_id_out, 1);
         check_eq("bp_P", bus.P_out, tri_word(1));
         check_eq("bp_no_rd_en", bus.tri_rd_en_out, 1'b0);
      end
      bus.ready_in = 1'b1;
      wait_done("bp", 200, lat);
      check_eq("bp_id_count", id_log.size(), 3);
      ones = 0;
      foreach (id_log[i]) if (id_log[i] == 1) ones++;
      check_eq("bp_tri1_issued_once", ones, 1);
      check_eq("bp_P_bad", p_bad, 0);
      check_eq("bp_fb_sel", fb_sel_out, 1'b0);

      // Zero triangles.
      clear_logs();
      start_pulse(0);
      lat = 0;
      while (!frame_done_out && lat < 20) begin @(negedge clk); lat++; end
      check_eq("zero_done_lat", lat, 2);
      check_eq("zero_fb_sel", fb_sel_out, 1'b1);
      check_eq("zero_rd_count", rd_log.size(), 0);
      check_eq("zero_id_count", id_log.size(), 0);
      @(negedge clk);
      check_eq("zero_busy_low", busy_out, 1'b0);

      // Clamping: 4095 requested, NUM_TRI issued.
      clear_logs();
      start_pulse(4095);
      wait_done("clamp", 20000, lat);
      check_eq("clamp_id_count", id_log.size(), NT);
      check_eq("clamp_rd_count", rd_log.size(), NT);
      if (id_log.size() > 0) check_eq("clamp_last_id", id_log[id_log.size()-1], NT - 1);
      check_eq("clamp_P_bad", p_bad, 0);
      check_eq("clamp_fb_sel", fb_sel_out, 1'b0);

      // Asynchronous reset while triangle 5 is presented.
      clear_logs();
      start_pulse(8);
      lat = 0;
      while (!(bus.valid_out && bus.tri_id_out == TW'(5)) && lat < 200) begin
         @(negedge clk); lat++;
      end
      check_eq("mid_reach_tri5", bus.valid_out && bus.tri_id_out == TW'(5), 1'b1);
      check_eq("mid_outstanding_nonzero", outstanding_out != '0, 1'b1);
      #3 rst_in = 1'b1;
      #1;
      check_eq("mid_rst_valid", bus.valid_out, 1'b0);
      check_eq("mid_rst_busy", busy_out, 1'b0);
      check_eq("mid_rst_outstanding", outstanding_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);
      clear_logs();
      start_pulse(2);
      wait_valid("restart", 50, lat);
      check_eq("restart_first_id", bus.tri_id_out, 0);
      wait_done("restart", 200, lat);
      check_eq("restart_id_count", id_log.size(), 2);
      check_eq("restart_fb_sel", fb_sel_out, 1'b1);

`ifdef SCHED_WATCHDOG_EN
      // Watchdog: two issued, one completion returned.
      clear_logs();
      comp_sent = 0;
      comp_limit = 1;
      start_pulse(2);
      wait_done("wd", 400, lat);
      check_eq("wd_drain_cycles", done_cyc - hs_cyc, 102);
      check_eq("wd_timeout", timeout_out, 1'b1);
      repeat (5) @(negedge clk);
      check_eq("wd_timeout_sticky", timeout_out, 1'b1);
      comp_limit = 1 << 30;
      start_pulse(0);
      check_eq("wd_timeout_cleared", timeout_out, 1'b0);
      wait_done("wd_next", 20, lat);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
